jar_pi_recite: RTL and testbench

Pi-recitation checker: the player keys hexadecimal digits of pi one at a time on four switches plus an enter button, and the block compares each entry against the digit ROM at the current position. It tracks the current streak and best streak and latches the expected digit on a miss. It sits between the board's switch/button inputs and the shared `seg7hex` display encoder. It is the input-side counterpart of the pi digit display path, consuming digits rather than producing them.

---
 rtl/jar_pi_pkg.sv | 28 ++
 rtl/jar_pi_digit_rom.sv | 11 +
 rtl/jar_pi_recite.sv | 136 +++++++++++++
 tb/tb_jar_pi_recite.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jar_pi_pkg.sv
// Shared definitions for the pi-recitation checker and the pi digit display path.
// Holds the recitation state encoding and the first 256 hex digits of pi.
package jar_pi_pkg;

    localparam int PI_DIGITS = 256;
    localparam int PI_IDX_W  = 8;
    localparam int DIGIT_W   = 4;

    typedef enum logic [1:0] {
        READY = 2'd0,
        FAIL  = 2'd1,
        DONE  = 2'd2
    } pi_state_e;

    // Digit 0 (the integer 3) sits in the most significant nibble.
    localparam logic [4*PI_DIGITS-1:0] PI_HEX = {
        256'h3243F6A8_885A308D_313198A2_E0370734_4A409382_2299F31D_0082EFA9_8EC4E6C8,
        256'h9452821E_638D0137_7BE5466C_F34E90C6_CC0AC29B_7C97C50D_D3F84D5B_5B547091,
        256'h79216D5D_98979FB1_BD1310BA_698DFB5A_C2FFD72D_BD01ADFB_7B8E1AFE_D6A267E9,
        256'h6BA7C904_5F12C7F9_924A1994_7B3916CF_70801F2E_2858EFC1_6636920D_871574E6
    };

    // Nibble offset of digit idx is (255 - idx) * 4, i.e. {~idx, 2'b00}.
    function automatic logic [DIGIT_W-1:0] pi_digit(input logic [PI_IDX_W-1:0] idx);
        return PI_HEX[{~idx, 2'b00} +: DIGIT_W];
    endfunction

endpackage

// File: rtl/jar_pi_digit_rom.sv
// Combinational pi digit table: 8-bit position in, 4-bit hex digit out.
module jar_pi_digit_rom
    import jar_pi_pkg::*;
(
    input  logic [PI_IDX_W-1:0] idx,
    output logic [DIGIT_W-1:0]  digit
);

    assign digit = pi_digit(idx);

endmodule

// File: rtl/jar_pi_recite.sv
// Pi-recitation checker: synchronises switch/button inputs, compares keyed digits
// against the pi ROM and tracks the current and best streak.
module jar_pi_recite
    import jar_pi_pkg::*;
#(
    parameter int LOCKOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       restart,
    output logic [3:0] disp,
    output logic [8:0] streak,
    output logic [8:0] best,
    output logic       ok,
    output logic       fail,
    output logic       done
);

    localparam int LOCK_W = (LOCKOUT < 2) ? 1 : $clog2(LOCKOUT + 1);

    logic [DIGIT_W-1:0]  digit_s1_r;
    logic [DIGIT_W-1:0]  digit_s2_r;
    logic                enter_s1_r;
    logic                enter_s2_r;
    logic                enter_prev_r;
    logic                enter_edge_r;
    logic                restart_s1_r;
    logic                restart_s2_r;
    logic                restart_prev_r;
    logic                restart_edge_r;
    logic [PI_IDX_W-1:0] pos_r;
    logic [LOCK_W-1:0]   lock_r;
    pi_state_e           state_r;
    logic [DIGIT_W-1:0]  rom_digit_s;
    logic [8:0]          next_streak_s;

    jar_pi_digit_rom u_rom (
        .idx   (pos_r),
        .digit (rom_digit_s)
    );

    assign next_streak_s = streak + 9'd1;

    // Two-flop synchronisers plus registered rising-edge detection of the buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_s1_r     <= 4'd0;
            digit_s2_r     <= 4'd0;
            enter_s1_r     <= 1'b0;
            enter_s2_r     <= 1'b0;
            enter_prev_r   <= 1'b0;
            enter_edge_r   <= 1'b0;
            restart_s1_r   <= 1'b0;
            restart_s2_r   <= 1'b0;
            restart_prev_r <= 1'b0;
            restart_edge_r <= 1'b0;
        end else begin
            digit_s1_r     <= digit;
            digit_s2_r     <= digit_s1_r;
            enter_s1_r     <= enter;
            enter_s2_r     <= enter_s1_r;
            enter_prev_r   <= enter_s2_r;
            enter_edge_r   <= enter_s2_r & ~enter_prev_r;
            restart_s1_r   <= restart;
            restart_s2_r   <= restart_s1_r;
            restart_prev_r <= restart_s2_r;
            restart_edge_r <= restart_s2_r & ~restart_prev_r;
        end
    end

    // Recitation FSM with registered outputs; restart overrides any enter in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= READY;
            pos_r   <= 8'd0;
            lock_r  <= '0;
            disp    <= 4'd0;
            streak  <= 9'd0;
            best    <= 9'd0;
            ok      <= 1'b0;
            fail    <= 1'b0;
            done    <= 1'b0;
        end else begin
            ok <= 1'b0;
            if (lock_r != '0) begin
                lock_r <= lock_r - LOCK_W'(1);
            end
            if (restart_edge_r) begin
                state_r <= READY;
                pos_r   <= 8'd0;
                lock_r  <= '0;
                disp    <= 4'd0;
                streak  <= 9'd0;
                fail    <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state_r)
                    READY: begin
                        if (enter_edge_r && (lock_r == '0)) begin
                            lock_r <= LOCK_W'(LOCKOUT);
                            if (digit_s2_r == rom_digit_s) begin
                                ok     <= 1'b1;
                                streak <= next_streak_s;
                                if (next_streak_s > best) begin
                                    best <= next_streak_s;
                                end
                                if (pos_r == 8'hFF) begin
                                    state_r <= DONE;
                                    done    <= 1'b1;
                                    disp    <= 4'hF;
                                end else begin
                                    pos_r <= pos_r + 8'd1;
                                    disp  <= digit_s2_r;
                                end
                            end else begin
                                state_r <= FAIL;
                                fail    <= 1'b1;
                                disp    <= rom_digit_s;
                            end
                        end
                    end
                    FAIL, DONE: begin
                    end
                    default: begin
                        state_r <= READY;
                        fail    <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jar_pi_recite.sv
// Self-checking bench for jar_pi_recite: hand-derived vector table, randomized
// presses against a timestamp-based game model, full 256-digit run and async reset.
module tb_jar_pi_recite;

    localparam int LOCK = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       enter = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] disp;
    logic [8:0] streak;
    logic [8:0] best;
    logic       ok;
    logic       fail;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    jar_pi_recite #(.LOCKOUT(LOCK)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .digit   (digit),
        .enter   (enter),
        .restart (restart),
        .disp    (disp),
        .streak  (streak),
        .best    (best),
        .ok      (ok),
        .fail    (fail),
        .done    (done)
    );

    always #5 clk = ~clk;

    string pi_str = {"3243F6A8885A308D313198A2E03707344A4093822299F31D0082EFA98EC4E6C8",
                     "9452821E638D01377BE5466CF34E90C6CC0AC29B7C97C50DD3F84D5B5B547091",
                     "79216D5D98979FB1BD1310BA698DFB5AC2FFD72DBD01ADFB7B8E1AFED6A267E9",
                     "6BA7C9045F12C7F9924A19947B3916CF70801F2E2858EFC16636920D871574E6"};
    int pi_tb [256];

    // Reference model: game rules applied to button edges seen 3 clocks late.
    logic en_h [0:4];
    logic rs_h [0:4];
    logic [3:0] dg_h [0:4];
    int   cyc;
    int   last_acc;
    int   m_mode;  // 0 ready, 1 missed, 2 finished
    int   m_pos;
    int   m_streak;
    int   m_best;
    int   m_disp;
    logic m_ok;

    function automatic int hexval(input byte c);
        if (c >= "A") return int'(c) - 55;
        return int'(c) - 48;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) begin
            en_h[i] = 1'b0;
            rs_h[i] = 1'b0;
            dg_h[i] = 4'd0;
        end
        cyc = 0; last_acc = -1000; m_mode = 0; m_pos = 0;
        m_streak = 0; m_best = 0; m_disp = 0; m_ok = 1'b0;
    endfunction

    function automatic void model_step();
        logic en_edge;
        logic rs_edge;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 4; i > 0; i--) begin
            en_h[i] = en_h[i-1];
            rs_h[i] = rs_h[i-1];
            dg_h[i] = dg_h[i-1];
        end
        en_h[0] = enter; rs_h[0] = restart; dg_h[0] = digit;
        cyc++;
        m_ok = 1'b0;
        en_edge = en_h[3] && !en_h[4];
        rs_edge = rs_h[3] && !rs_h[4];
        if (rs_edge) begin
            m_mode = 0; m_pos = 0; m_streak = 0; m_disp = 0; last_acc = -1000;
        end else if (en_edge && m_mode == 0 && (cyc - last_acc) > LOCK) begin
            last_acc = cyc;
            if (int'(dg_h[2]) == pi_tb[m_pos]) begin
                m_ok = 1'b1;
                m_streak++;
                if (m_streak > m_best) m_best = m_streak;
                if (m_pos == 255) begin
                    m_mode = 2; m_disp = 15;
                end else begin
                    m_disp = int'(dg_h[2]); m_pos++;
                end
            end else begin
                m_mode = 1; m_disp = pi_tb[m_pos];
            end
        end
    endfunction

    task automatic check_cycle();
        logic [24:0] exp_v;
        logic [24:0] act_v;
        exp_v = {4'(m_disp), 9'(m_streak), 9'(m_best), m_ok, (m_mode == 1), (m_mode == 2)};
        act_v = {disp, streak, best, ok, fail, done};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle%0d t=%0t: got disp=%h streak=%0d best=%0d ok=%b fail=%b done=%b, want disp=%h streak=%0d best=%0d ok=%b fail=%b done=%b",
                     cyc, $time, disp, streak, best, ok, fail, done,
                     exp_v[24:21], exp_v[20:12], exp_v[11:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic press(input logic rs, input logic en, input logic [3:0] d,
                         input int hold, input int gap);
        digit = d;
        step(); step();
        enter = en; restart = rs;
        repeat (hold) step();
        enter = 1'b0; restart = 1'b0;
        repeat (gap - 2 - hold) step();
    endtask

    typedef struct {
        logic       rs;
        logic       en;
        logic [3:0] d;
        int         gap;
        int         exp_streak;
        int         exp_best;
        logic       exp_fail;
        logic [3:0] exp_disp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        for (int i = 0; i < 256; i++) pi_tb[i] = hexval(pi_str[i]);
        model_reset();

        // Table: correct run, miss, ignored entry, restart, lockout, simultaneous events.
        tbl[0]  = '{1'b0, 1'b1, 4'h3, 24, 1, 1, 1'b0, 4'h3};
        tbl[1]  = '{1'b0, 1'b1, 4'h2, 24, 2, 2, 1'b0, 4'h2};
        tbl[2]  = '{1'b0, 1'b1, 4'h4, 24, 3, 3, 1'b0, 4'h4};
        tbl[3]  = '{1'b0, 1'b1, 4'h3, 24, 4, 4, 1'b0, 4'h3};
        tbl[4]  = '{1'b0, 1'b1, 4'hF, 24, 5, 5, 1'b0, 4'hF};
        tbl[5]  = '{1'b1, 1'b0, 4'h0, 24, 0, 5, 1'b0, 4'h0};
        tbl[6]  = '{1'b0, 1'b1, 4'h3, 24, 1, 5, 1'b0, 4'h3};
        tbl[7]  = '{1'b0, 1'b1, 4'h2, 24, 2, 5, 1'b0, 4'h2};
        tbl[8]  = '{1'b0, 1'b1, 4'h5, 24, 2, 5, 1'b1, 4'h4};
        tbl[9]  = '{1'b0, 1'b1, 4'h4, 24, 2, 5, 1'b1, 4'h4};
        tbl[10] = '{1'b1, 1'b0, 4'h0, 24, 0, 5, 1'b0, 4'h0};
        tbl[11] = '{1'b0, 1'b1, 4'h3, 10, 1, 5, 1'b0, 4'h3};
        tbl[12] = '{1'b0, 1'b1, 4'h2, 10, 1, 5, 1'b0, 4'h3};
        tbl[13] = '{1'b0, 1'b1, 4'h2, 24, 2, 5, 1'b0, 4'h2};
        tbl[14] = '{1'b0, 1'b1, 4'h4, 24, 3, 5, 1'b0, 4'h4};
        tbl[15] = '{1'b1, 1'b1, 4'h3, 24, 0, 5, 1'b0, 4'h0};

        // Reset held with random inputs, then released with quiet inputs.
        repeat (6) begin
            digit = 4'($urandom_range(0, 15));
            enter = 1'($urandom_range(0, 1));
            restart = 1'($urandom_range(0, 1));
            step();
        end
        digit = 4'd0; enter = 1'b0; restart = 1'b0;
        rst_n = 1'b1;
        repeat (10) step();

        for (int i = 0; i < 16; i++) begin
            press(tbl[i].rs, tbl[i].en, tbl[i].d, 4, tbl[i].gap);
            vectors++;
            if (streak !== 9'(tbl[i].exp_streak) || best !== 9'(tbl[i].exp_best) ||
                fail !== tbl[i].exp_fail || disp !== tbl[i].exp_disp) begin
                miscompares++;
                $display("FAIL vec%0d: got streak=%0d best=%0d fail=%b disp=%h, want streak=%0d best=%0d fail=%b disp=%h",
                         i, streak, best, fail, disp,
                         tbl[i].exp_streak, tbl[i].exp_best, tbl[i].exp_fail, tbl[i].exp_disp);
            end
        end

        // Randomized presses: mostly correct digits, occasional misses and restarts.
        for (int i = 0; i < 150; i++) begin
            int r;
            int hold;
            int gap;
            logic [3:0] d;
            r = int'($urandom_range(0, 99));
            hold = int'($urandom_range(1, 4));
            gap = int'($urandom_range(hold + 4, 30));
            d = (r < 75) ? 4'(pi_tb[m_pos]) : 4'($urandom_range(0, 15));
            if (r < 6) press(1'b1, 1'b0, d, hold, gap);
            else if (r < 9) press(1'b1, 1'b1, d, hold, gap);
            else press(1'b0, 1'b1, d, hold, gap);
        end

        // Full 256-digit recitation reaching DONE, then an ignored enter.
        press(1'b1, 1'b0, 4'd0, 3, 20);
        for (int i = 0; i < 256; i++) press(1'b0, 1'b1, 4'(pi_tb[i]), 3, 20);
        press(1'b0, 1'b1, 4'h3, 3, 20);
        vectors++;
        if (done !== 1'b1 || streak !== 9'd256 || best !== 9'd256 || disp !== 4'hF) begin
            miscompares++;
            $display("FAIL full_run: got done=%b streak=%0d best=%0d disp=%h, want done=1 streak=256 best=256 disp=f",
                     done, streak, best, disp);
        end

        // Asynchronous reset mid-DONE clears everything before the next clock edge.
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({disp, streak, best, ok, fail, done} !== 25'd0) begin
            miscompares++;
            $display("FAIL async_rst: got disp=%h streak=%0d best=%0d ok=%b fail=%b done=%b, want all 0",
                     disp, streak, best, ok, fail, done);
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
